controle_recepcao_serial: RTL and testbench

Receives ASCII commands on the RX line and maintains the run-time configuration of the level controller: three BCD distance thresholds (nv_crit, nv_alto, nv_baixo), manual/auto mode, and the manual valve request. It sits directly upstream of the project datapath's classifier and valve logic, which consume its outputs combinationally. The character format matches the TX side: digits are '0'–'9' (0x30 + BCD nibble), and '#' (0x23) terminates a command.

---
 rtl/controle_recepcao_serial_pkg.sv | 54 +++++
 rtl/rx_serial_8N1.sv | 92 +++++++++
 rtl/controle_recepcao_serial.sv | 231 +++++++++++++++++++++++
 tb/tb_controle_recepcao_serial.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/controle_recepcao_serial_pkg.sv
// Shared ASCII constants, state encodings and helpers for the serial command receiver.
// The character constants are also used by the TX mux, so keep them in sync with it.
package controle_recepcao_serial_pkg;

  localparam logic [7:0] ASC_M    = 8'h4D;
  localparam logic [7:0] ASC_A    = 8'h41;
  localparam logic [7:0] ASC_O    = 8'h4F;
  localparam logic [7:0] ASC_F    = 8'h46;
  localparam logic [7:0] ASC_C    = 8'h43;
  localparam logic [7:0] ASC_H    = 8'h48;
  localparam logic [7:0] ASC_L    = 8'h4C;
  localparam logic [7:0] ASC_HASH = 8'h23;
  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_9    = 8'h39;

  typedef enum logic [3:0] {
    OCIOSO = 4'd0,
    D2     = 4'd1,
    D1     = 4'd2,
    D0     = 4'd3,
    TERM   = 4'd4,
    VALIDA = 4'd5
  } estado_t;

  typedef enum logic [1:0] {
    SEL_CRIT  = 2'd0,
    SEL_ALTO  = 2'd1,
    SEL_BAIXO = 2'd2
  } sel_nivel_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_estado_t;

  function automatic logic eh_digito(input logic [7:0] b);
    return (b >= ASC_0) && (b <= ASC_9);
  endfunction

  function automatic logic eh_cmd_nivel(input logic [7:0] b);
    return (b == ASC_C) || (b == ASC_H) || (b == ASC_L);
  endfunction

  function automatic sel_nivel_t sel_de_ascii(input logic [7:0] b);
    sel_nivel_t s;
    if (b == ASC_C)      s = SEL_CRIT;
    else if (b == ASC_H) s = SEL_ALTO;
    else                 s = SEL_BAIXO;
    return s;
  endfunction

endpackage

// File: rtl/rx_serial_8N1.sv
// 8N1 UART receiver: start-bit detect, mid-bit sampling, stop-bit check.
// A low stop bit is treated as a framing error and the byte is dropped.
module rx_serial_8N1
  import controle_recepcao_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] dados_ascii,
  output logic       pronto
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] CARGA_MEIO = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CARGA_BIT  = CW'(CLKS_PER_BIT - 1);

  rx_estado_t    r_estado;
  rx_estado_t    w_prox;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_dados;
  logic          r_pronto;
  logic          w_rx;
  logic          w_tc;
  logic          w_pronto;

  assign w_rx = r_sync[1];
  assign w_tc = (r_cnt == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= RX_IDLE;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      RX_IDLE:  if (!w_rx) w_prox = RX_START;
      RX_START: if (w_tc) w_prox = w_rx ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_tc && (r_bit == 3'd7)) w_prox = RX_STOP;
      RX_STOP:  if (w_tc) w_prox = RX_IDLE;
      default:  w_prox = RX_IDLE;
    endcase
  end

  always_comb begin
    w_pronto = (r_estado == RX_STOP) && w_tc && w_rx;
  end

  // The counter doubles as half-bit delay in START and full-bit delay afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync   <= 2'b11;
      r_cnt    <= CARGA_MEIO;
      r_bit    <= 3'd0;
      r_dados  <= 8'h00;
      r_pronto <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], RX};
      r_pronto <= w_pronto;
      case (r_estado)
        RX_IDLE: begin
          r_cnt <= CARGA_MEIO;
          r_bit <= 3'd0;
        end
        RX_START: begin
          if (w_tc) r_cnt <= CARGA_BIT;
          else      r_cnt <= r_cnt - CW'(1);
        end
        RX_DATA: begin
          if (w_tc) begin
            r_cnt   <= CARGA_BIT;
            r_dados <= {w_rx, r_dados[7:1]};
            r_bit   <= r_bit + 3'd1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          if (!w_tc) r_cnt <= r_cnt - CW'(1);
        end
      endcase
    end
  end

  assign dados_ascii = r_dados;
  assign pronto      = r_pronto;

endmodule

// File: rtl/controle_recepcao_serial.sv
// Command decoder for the level controller: parses ASCII commands from the UART
// and holds the BCD thresholds plus manual/valve configuration.
//
// state  | meaning
// OCIOSO | idle, single-byte commands or threshold selector accepted
// D2     | waiting for hundreds digit
// D1     | waiting for tens digit
// D0     | waiting for units digit
// TERM   | waiting for '#'
// VALIDA | ordering check and threshold write
module controle_recepcao_serial
  import controle_recepcao_serial_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          TIMEOUT      = 50000000,
  parameter logic [11:0] NV_CRIT_RST  = 12'h010,
  parameter logic [11:0] NV_ALTO_RST  = 12'h020,
  parameter logic [11:0] NV_BAIXO_RST = 12'h080
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RX,
  output logic [11:0] nv_crit,
  output logic [11:0] nv_alto,
  output logic [11:0] nv_baixo,
  output logic        manual,
  output logic        abrir_valv,
  output logic        cmd_ok,
  output logic        cmd_erro,
  output logic [3:0]  db_estado
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_CARGA = TO_W'(TIMEOUT - 1);

  estado_t         r_estado;
  estado_t         w_prox;
  logic [11:0]     r_crit;
  logic [11:0]     r_alto;
  logic [11:0]     r_baixo;
  logic [11:0]     r_buf;
  sel_nivel_t      r_sel;
  logic            r_manual;
  logic            r_abrir;
  logic            r_ok;
  logic            r_erro;
  logic [TO_W-1:0] r_to_cnt;

  logic [7:0]  w_b;
  logic        w_p;
  logic        w_timeout;
  logic [11:0] w_crit_c;
  logic [11:0] w_alto_c;
  logic [11:0] w_baixo_c;
  logic        w_valido;
  logic        w_ok;
  logic        w_erro;
  logic        w_set_man;
  logic        w_clr_man;
  logic        w_set_abr;
  logic        w_clr_abr;
  logic        w_carga_sel;
  logic        w_shift;
  logic        w_grava;

  rx_serial_8N1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock       (clock),
    .reset       (reset),
    .RX          (RX),
    .dados_ascii (w_b),
    .pronto      (w_p)
  );

  assign w_timeout = (r_estado inside {D2, D1, D0, TERM}) && (r_to_cnt == '0);

  // Candidate triple: the buffer replaces the selected threshold only.
  assign w_crit_c  = (r_sel == SEL_CRIT)  ? r_buf : r_crit;
  assign w_alto_c  = (r_sel == SEL_ALTO)  ? r_buf : r_alto;
  assign w_baixo_c = (r_sel == SEL_BAIXO) ? r_buf : r_baixo;
  assign w_valido  = (w_crit_c < w_alto_c) && (w_alto_c < w_baixo_c);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= OCIOSO;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      OCIOSO: if (w_p && eh_cmd_nivel(w_b)) w_prox = D2;
      D2: begin
        if (w_p)            w_prox = eh_digito(w_b) ? D1 : OCIOSO;
        else if (w_timeout) w_prox = OCIOSO;
      end
      D1: begin
        if (w_p)            w_prox = eh_digito(w_b) ? D0 : OCIOSO;
        else if (w_timeout) w_prox = OCIOSO;
      end
      D0: begin
        if (w_p)            w_prox = eh_digito(w_b) ? TERM : OCIOSO;
        else if (w_timeout) w_prox = OCIOSO;
      end
      TERM: begin
        if (w_p)            w_prox = (w_b == ASC_HASH) ? VALIDA : OCIOSO;
        else if (w_timeout) w_prox = OCIOSO;
      end
      VALIDA:  w_prox = OCIOSO;
      default: w_prox = OCIOSO;
    endcase
  end

  always_comb begin
    w_ok        = 1'b0;
    w_erro      = 1'b0;
    w_set_man   = 1'b0;
    w_clr_man   = 1'b0;
    w_set_abr   = 1'b0;
    w_clr_abr   = 1'b0;
    w_carga_sel = 1'b0;
    w_shift     = 1'b0;
    w_grava     = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (w_p) begin
          case (w_b)
            ASC_M: begin
              w_set_man = 1'b1;
              w_ok      = 1'b1;
            end
            ASC_A: begin
              w_clr_man = 1'b1;
              w_clr_abr = 1'b1;
              w_ok      = 1'b1;
            end
            ASC_O: begin
              if (r_manual) begin
                w_set_abr = 1'b1;
                w_ok      = 1'b1;
              end else begin
                w_erro = 1'b1;
              end
            end
            ASC_F: begin
              w_clr_abr = 1'b1;
              w_ok      = 1'b1;
            end
            ASC_C, ASC_H, ASC_L: w_carga_sel = 1'b1;
            default: ;
          endcase
        end
      end
      D2, D1, D0: begin
        if (w_p) begin
          if (eh_digito(w_b)) w_shift = 1'b1;
          else                w_erro  = 1'b1;
        end else if (w_timeout) begin
          w_erro = 1'b1;
        end
      end
      TERM: begin
        if (w_p) begin
          if (w_b != ASC_HASH) w_erro = 1'b1;
        end else if (w_timeout) begin
          w_erro = 1'b1;
        end
      end
      VALIDA: begin
        if (w_valido) begin
          w_grava = 1'b1;
          w_ok    = 1'b1;
        end else begin
          w_erro = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_crit   <= NV_CRIT_RST;
      r_alto   <= NV_ALTO_RST;
      r_baixo  <= NV_BAIXO_RST;
      r_buf    <= 12'h000;
      r_sel    <= SEL_CRIT;
      r_manual <= 1'b0;
      r_abrir  <= 1'b0;
      r_ok     <= 1'b0;
      r_erro   <= 1'b0;
      r_to_cnt <= TO_CARGA;
    end else begin
      r_ok   <= w_ok;
      r_erro <= w_erro;

      if (w_set_man)      r_manual <= 1'b1;
      else if (w_clr_man) r_manual <= 1'b0;

      if (w_set_abr)      r_abrir <= 1'b1;
      else if (w_clr_abr) r_abrir <= 1'b0;

      if (w_carga_sel) begin
        r_sel <= sel_de_ascii(w_b);
        r_buf <= 12'h000;
      end else if (w_shift) begin
        r_buf <= {r_buf[7:0], w_b[3:0]};
      end

      if (w_grava) begin
        case (r_sel)
          SEL_CRIT: r_crit  <= r_buf;
          SEL_ALTO: r_alto  <= r_buf;
          default:  r_baixo <= r_buf;
        endcase
      end

      // Timeout down-counter: reloaded on every byte and held while idle.
      if (w_p || (r_estado == OCIOSO) || (r_estado == VALIDA)) r_to_cnt <= TO_CARGA;
      else if (r_to_cnt != '0)                                 r_to_cnt <= r_to_cnt - TO_W'(1);
    end
  end

  assign nv_crit    = r_crit;
  assign nv_alto    = r_alto;
  assign nv_baixo   = r_baixo;
  assign manual     = r_manual;
  assign abrir_valv = r_abrir;
  assign cmd_ok     = r_ok;
  assign cmd_erro   = r_erro;
  assign db_estado  = r_estado;

endmodule

// File: tb/tb_controle_recepcao_serial.sv
// Scoreboard bench: expected command responses are queued before each byte is sent
// and a monitor pops them whenever cmd_ok or cmd_erro pulses.
module tb_controle_recepcao_serial;

  localparam int CPB = 8;
  localparam int TO  = 1000;

  logic        clock;
  logic        reset;
  logic        RX;
  logic [11:0] nv_crit;
  logic [11:0] nv_alto;
  logic [11:0] nv_baixo;
  logic        manual;
  logic        abrir_valv;
  logic        cmd_ok;
  logic        cmd_erro;
  logic [3:0]  db_estado;

  controle_recepcao_serial #(
    .CLKS_PER_BIT (CPB),
    .TIMEOUT      (TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .RX         (RX),
    .nv_crit    (nv_crit),
    .nv_alto    (nv_alto),
    .nv_baixo   (nv_baixo),
    .manual     (manual),
    .abrir_valv (abrir_valv),
    .cmd_ok     (cmd_ok),
    .cmd_erro   (cmd_erro),
    .db_estado  (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ok;
    logic [11:0] crit;
    logic [11:0] alto;
    logic [11:0] baixo;
    logic        man;
    logic        abr;
    int          lat;
  } exp_t;

  exp_t fila[$];
  exp_t e_mon;
  int   n_chk;
  int   n_fail;
  int   cyc;

  logic [11:0] m_crit;
  logic [11:0] m_alto;
  logic [11:0] m_baixo;
  logic        m_man;
  logic        m_abr;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nome, act, req, $time);
    end
  endtask

  task automatic esperar(input logic ok, input int lat);
    exp_t e;
    e.ok    = ok;
    e.crit  = m_crit;
    e.alto  = m_alto;
    e.baixo = m_baixo;
    e.man   = m_man;
    e.abr   = m_abr;
    e.lat   = lat;
    fila.push_back(e);
  endtask

  task automatic enviar(input logic [7:0] b);
    RX = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (CPB) @(negedge clock);
    end
    RX = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic enviar_str(input string s);
    for (int i = 0; i < s.len(); i++) enviar(s[i]);
  endtask

  task automatic modelo_reset();
    m_crit  = 12'h010;
    m_alto  = 12'h020;
    m_baixo = 12'h080;
    m_man   = 1'b0;
    m_abr   = 1'b0;
  endtask

  task automatic chk_saidas(input string nome);
    chk({nome, "_crit"},  32'(nv_crit),    32'(m_crit));
    chk({nome, "_alto"},  32'(nv_alto),    32'(m_alto));
    chk({nome, "_baixo"}, 32'(nv_baixo),   32'(m_baixo));
    chk({nome, "_man"},   32'(manual),     32'(m_man));
    chk({nome, "_abr"},   32'(abrir_valv), 32'(m_abr));
  endtask

  // Monitor: latency is counted from the receiver's byte-ready pulse.
  initial begin
    cyc = 100;
    forever begin
      @(negedge clock);
      if (dut.u_rx.pronto) cyc = 0;
      else if (cyc < 100000) cyc++;
      if (cmd_ok || cmd_erro) begin
        if (fila.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL pulso_inesperado: got ok=%0b erro=%0b, required no pulse (t=%0t)",
                   cmd_ok, cmd_erro, $time);
        end else begin
          e_mon = fila.pop_front();
          chk("pulso_ok",   32'(cmd_ok),     32'(e_mon.ok));
          chk("pulso_erro", 32'(cmd_erro),   32'(!e_mon.ok));
          chk("mon_crit",   32'(nv_crit),    32'(e_mon.crit));
          chk("mon_alto",   32'(nv_alto),    32'(e_mon.alto));
          chk("mon_baixo",  32'(nv_baixo),   32'(e_mon.baixo));
          chk("mon_man",    32'(manual),     32'(e_mon.man));
          chk("mon_abr",    32'(abrir_valv), 32'(e_mon.abr));
          if (e_mon.lat > 0) chk("latencia", 32'(cyc), 32'(e_mon.lat));
        end
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    RX     = 1'b1;
    reset  = 1'b0;
    modelo_reset();
    repeat (5) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_saidas("reset");
    chk("reset_estado", 32'(db_estado), 32'd0);
    chk("reset_pulsos", 32'({cmd_ok, cmd_erro}), 32'd0);

    enviar_str("H050");
    m_alto = 12'h050;
    esperar(1'b1, 2);
    enviar("#");

    enviar_str("H005");
    esperar(1'b0, 2);
    enviar("#");

    esperar(1'b0, 1);
    enviar("O");
    m_man = 1'b1;
    esperar(1'b1, 1);
    enviar("M");
    m_abr = 1'b1;
    esperar(1'b1, 1);
    enviar("O");
    m_man = 1'b0;
    m_abr = 1'b0;
    esperar(1'b1, 1);
    enviar("A");

    enviar("m");
    enviar(8'h0D);
    enviar(8'h0A);

    enviar_str("L0");
    esperar(1'b0, 1);
    enviar("X");
    enviar_str("5#");

    // crit equal to alto must be rejected
    enviar_str("C050");
    esperar(1'b0, 2);
    enviar("#");

    enviar_str("C01");
    esperar(1'b0, -1);
    repeat (TO + 20 * CPB) @(negedge clock);
    chk("timeout_estado", 32'(db_estado), 32'd0);
    chk("timeout_fila", 32'(fila.size()), 32'd0);

    enviar_str("C015");
    m_crit = 12'h015;
    esperar(1'b1, 2);
    enviar("#");

    esperar(1'b1, 1);
    enviar("F");
    chk_saidas("pre_reset");

    enviar_str("L0");
    RX = 1'b0;
    repeat (CPB) @(negedge clock);
    RX = 1'b1;
    repeat (3 * CPB) @(negedge clock);
    reset = 1'b0;
    RX    = 1'b1;
    modelo_reset();
    repeat (3) @(negedge clock);
    chk_saidas("reset_meio");
    chk("reset_meio_estado", 32'(db_estado), 32'd0);
    reset = 1'b1;
    repeat (3 * CPB) @(negedge clock);

    enviar_str("L099");
    m_baixo = 12'h099;
    esperar(1'b1, 2);
    enviar("#");

    repeat (4 * CPB) @(negedge clock);
    chk_saidas("final");
    chk("fila_vazia", 32'(fila.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
